// File: rtl/axis_gain_ramp_controller.sv
// Gain ramp controller: debounces the volume switches and the mute input, then
// walks the gain code one LSB at a time toward the requested level, applying each
// step only on a stereo-frame boundary of the monitored rx AXI-stream.
module axis_gain_ramp_controller #(
  parameter int SWITCH_WIDTH    = 4,
  parameter int DEBOUNCE_CYCLES = 225_000,
  parameter int RAMP_FRAMES     = 1
) (
  input  logic                    axis_clk,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    mute,
  input  logic                    frame_valid,
  input  logic                    frame_ready,
  input  logic                    frame_last,
  output logic [SWITCH_WIDTH-1:0] gain,
  output logic                    gain_update,
  output logic                    busy,
  output logic                    muted
);

  localparam int VW  = SWITCH_WIDTH + 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FCW = $clog2(RAMP_FRAMES + 1);
  localparam logic [DCW-1:0] DEB_MAX   = DCW'(DEBOUNCE_CYCLES);
  localparam logic [FCW-1:0] FRAME_MAX = FCW'(RAMP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STEP
  } state_t;

  logic [VW-1:0]           sync_meta;
  logic [VW-1:0]           sync_out;
  logic [VW-1:0]           sync_prev;
  logic [DCW-1:0]          deb_cnt;
  logic [SWITCH_WIDTH-1:0] sw_stable;
  logic [SWITCH_WIDTH-1:0] target;
  logic                    fb;

  state_t                  state_q, state_d;
  logic [SWITCH_WIDTH-1:0] gain_d;
  logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [FCW-1:0]          frame_cnt_inc;
  logic                    gain_update_d;

  // Two-flop synchronizer on the raw {mute, sw} pins.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so the two stages really form a two-cycle shift chain.
      sync_meta <= {mute, sw};
      sync_out  <= sync_meta;
    end
  end

  // One shared stability counter; the vector is accepted once it has held
  // DEBOUNCE_CYCLES cycles, and the counter then parks at its maximum.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      sync_prev <= '0;
      deb_cnt   <= '0;
      sw_stable <= '0;
      muted     <= 1'b0;
    end else begin
      sync_prev <= sync_out;
      if (sync_out != sync_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + DCW'(1);
        if (deb_cnt == DEB_MAX - DCW'(1)) begin
          {muted, sw_stable} <= sync_out;
        end
      end
    end
  end

  assign target = muted ? '0 : sw_stable;
  assign fb     = frame_valid & frame_ready & frame_last;
  assign busy   = (state_q != S_IDLE) | (gain != target);
  assign frame_cnt_inc = frame_cnt_q + FCW'(1);

  // Ramp FSM state, gain code and update pulse registers.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gain        <= '0;
      frame_cnt_q <= '0;
      gain_update <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain        <= gain_d;
      frame_cnt_q <= frame_cnt_d;
      gain_update <= gain_update_d;
    end
  end

  // Next-state logic: wait RAMP_FRAMES boundaries, then move one code toward target.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    state_d       = state_q;
    gain_d        = gain;
    frame_cnt_d   = frame_cnt_q;
    gain_update_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gain != target) begin
          frame_cnt_d = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (target == gain) begin
          state_d = S_IDLE;
        end else if (fb) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == FRAME_MAX) state_d = S_STEP;
        end
      end
      S_STEP: begin
        // Direction uses the target as it stands now, so a target that crossed
        // over mid-ramp turns the ramp around without overshoot.
        if (target > gain) begin
          gain_d        = gain + SWITCH_WIDTH'(1);
          gain_update_d = 1'b1;
        end else if (target < gain) begin
          gain_d        = gain - SWITCH_WIDTH'(1);
          gain_update_d = 1'b1;
        end
        if (gain_d == target) begin
          state_d = S_IDLE;
        end else begin
          frame_cnt_d = '0;
          state_d     = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_gain_ramp_controller.sv
// Directed bench for axis_gain_ramp_controller with DEBOUNCE_CYCLES=4, RAMP_FRAMES=2
// and a frame boundary every 16 cycles.
module tb_axis_gain_ramp_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       mute;
  logic       frame_valid, frame_ready, frame_last;
  logic [3:0] gain;
  logic       gain_update, busy, muted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_times[$];
  bit fb_en = 1'b0;
  bit mon_en = 1'b0;
  logic [3:0] prev_gain = '0;

  axis_gain_ramp_controller #(
    .SWITCH_WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .RAMP_FRAMES(2)
  ) dut (
    .axis_clk(clk),
    .reset(reset),
    .sw(sw),
    .mute(mute),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_last(frame_last),
    .gain(gain),
    .gain_update(gain_update),
    .busy(busy),
    .muted(muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_gain(input logic [3:0] v, input int limit, input string tag);
    int n = 0;
    while (gain !== v && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, gain, v);
  endtask

  task automatic check_intervals(input string tag);
    for (int i = 1; i < pulse_times.size(); i++)
      check(tag, pulse_times[i] - pulse_times[i-1], 32);
  endtask

  // Stream traffic (only every 16th cycle is a real frame boundary, with decoy
  // words that miss last or ready) plus a monitor of every gain change.
  initial begin
    frame_valid = 1'b0;
    frame_ready = 1'b0;
    frame_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      frame_valid = fb_en && ((cyc % 8 == 0) || (cyc % 16 == 4));
      frame_ready = fb_en && (cyc % 8 == 0);
      frame_last  = fb_en && ((cyc % 16 == 0) || (cyc % 16 == 4));
      if (mon_en && (gain !== prev_gain || gain_update === 1'b1)) begin
        check("pulse_matches_change", gain_update, gain !== prev_gain);
        if (gain_update === 1'b1) begin
          check("step_size", (gain > prev_gain) ? gain - prev_gain : prev_gain - gain, 1);
          pulse_cnt++;
          pulse_times.push_back(cyc);
        end
      end
      prev_gain = gain;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sw    = 4'hA;
    mute  = 1'b0;
    fb_en = 1'b1;
    tick(3);

    // Power-up with sw=A: silent until debounced, then fade in to A.
    reset = 1'b0;
    check("rst_gain", gain, 4'h0);
    check("rst_update", gain_update, 1'b0);
    check("rst_muted", muted, 1'b0);
    check("rst_busy", busy, 1'b0);
    mon_en = 1'b1;
    tick(5);
    check("predeb_gain", gain, 4'h0);
    check("predeb_busy", busy, 1'b0);
    pulse_cnt = 0;
    pulse_times.delete();
    wait_gain(4'hA, 1000, "fadein_gain");
    check("fadein_last_pulse", gain_update, 1'b1);
    check("fadein_busy_fall", busy, 1'b0);
    check("fadein_pulses", pulse_cnt, 10);
    check_intervals("fadein_interval");

    // Chattering switches never get accepted.
    tick(5);
    pulse_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      sw = (i % 2 == 0) ? 4'h5 : 4'hA;
      tick(3);
      check("chatter_gain", gain, 4'hA);
    end
    tick(10);
    check("chatter_pulses", pulse_cnt, 0);
    check("chatter_busy", busy, 1'b0);

    // Mute ramps down to 0, unmute ramps back to A.
    mute = 1'b1;
    tick(6);
    check("mute_lat_early", muted, 1'b0);
    tick(1);
    check("mute_lat", muted, 1'b1);
    check("mute_busy", busy, 1'b1);
    pulse_cnt = 0;
    pulse_times.delete();
    wait_gain(4'h0, 1000, "mute_gain");
    check("mute_pulses", pulse_cnt, 10);
    check_intervals("mute_interval");
    tick(40);
    check("mute_hold", gain, 4'h0);
    mute = 1'b0;
    pulse_cnt = 0;
    wait_gain(4'hA, 1000, "unmute_gain");
    check("unmute_pulses", pulse_cnt, 10);
    check("unmute_muted", muted, 1'b0);

    // Up-ramp retargeted below the current gain turns around at the next step.
    sw = 4'h1;
    wait_gain(4'h1, 1000, "down_to_1");
    tick(5);
    sw = 4'hF;
    wait_gain(4'h8, 1000, "up_to_8");
    sw = 4'h3;
    pulse_cnt = 0;
    for (int n = 0; n < 100 && gain === 4'h8; n++) tick(1);
    check("turnaround_gain", gain, 4'h7);
    wait_gain(4'h3, 1000, "retarget_gain");
    tick(40);
    check("retarget_hold", gain, 4'h3);
    check("retarget_busy", busy, 1'b0);
    check("retarget_pulses", pulse_cnt, 5);

    // Target moves back to the current gain while waiting: no step happens.
    pulse_cnt = 0;
    sw = 4'h5;
    tick(7);
    check("revert_busy_wait", busy, 1'b1);
    sw = 4'h3;
    tick(9);
    check("revert_busy", busy, 1'b0);
    check("revert_gain", gain, 4'h3);
    check("revert_pulses", pulse_cnt, 0);

    // Stalled stream freezes the ramp; reset in WAIT clears asynchronously.
    fb_en = 1'b0;
    sw = 4'h9;
    tick(60);
    check("stall_gain", gain, 4'h3);
    check("stall_busy", busy, 1'b1);
    check("stall_pulses", pulse_cnt, 0);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_gain", gain, 4'h0);
    check("async_rst_update", gain_update, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(20);
    check("post_rst_gain", gain, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_gain_ramp_controller.md
# axis_gain_ramp_controller

Configuration controller for the stream volume controller. It debounces the volume switches and the mute input, then steps the gain code fed to the volume controller by one LSB at a time. Each step is applied only on a stereo-frame boundary of the Line-In AXI-stream, which avoids zipper noise and clicks. It sits between the board switches and the `sw` input of the volume controller, and passively monitors the rx stream handshake (`axis_rx_valid/ready/last`).

## Interface
- `SWITCH_WIDTH`, 4, width of switch input and gain code
- `DEBOUNCE_CYCLES`, 225_000, consecutive stable cycles required to accept a new input value (about 10 ms at axis_clk 22.5792 MHz); must be ≥1
- `RAMP_FRAMES`, 1, frame boundaries per gain step; must be ≥1

- `axis_clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `sw`  in  SWITCH_WIDTH  raw, asynchronous volume switches
- `mute`  in  1  raw, asynchronous mute request
- `frame_valid`  in  1  monitored stream valid
- `frame_ready`  in  1  monitored stream ready
- `frame_last`  in  1  monitored stream last (right-channel word)
- `gain`  out  SWITCH_WIDTH  gain code to the volume controller
- `gain_update`  out  1  one-cycle pulse coincident with each new `gain` value
- `busy`  out  1  high while `gain` ≠ target
- `muted`  out  1  debounced mute state

## Operation
- **Input synchronizer.** A 2-flop synchronizer on each bit of `{mute, sw}`.
- **Debouncer.** A single counter covers the whole synchronized vector.
  - Any change versus the previous synchronized sample clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the vector is latched into `sw_stable` and `muted`.
  - The counter saturates after the latch and does not wrap.
- **Target.** `target = muted ? 0 : sw_stable`, evaluated combinationally every cycle.
- **Frame boundary.** `fb = frame_valid & frame_ready & frame_last`.
- **FSM, IDLE.**
  - If `gain == target`, stay in IDLE.
  - Otherwise clear `frame_cnt` and go to WAIT.
- **FSM, WAIT.**
  - If `target == gain`, return to IDLE. This covers a target that moves back mid-ramp.
  - Otherwise, each `fb` increments `frame_cnt`. When an `fb` makes `frame_cnt == RAMP_FRAMES`, go to STEP.
- **FSM, STEP** (one cycle).
  - Set `gain <= gain + 1` if `target > gain`, or `gain <= gain − 1` if `target < gain`, and assert `gain_update <= 1`.
  - The direction is re-evaluated with the target current in this cycle.
  - If the new gain equals the target, go to IDLE. Otherwise clear `frame_cnt` and go to WAIT.
  - An `fb` arriving in the STEP cycle is dropped.
  - If the target equals `gain` in the STEP cycle, no change and no pulse occur; go to IDLE.
- **Width rules.**
  - `gain` never wraps. Moving toward the target bounds it to 0..2^SWITCH_WIDTH−1.
  - `frame_cnt` is clog2(RAMP_FRAMES+1) bits wide.
- `busy = (state != IDLE) | (gain != target)`, combinational.
- The monitored stream is never driven or stalled by this block.

## Timing
- **Reset values.** `gain = 0`, `gain_update = 0`, `muted = 0`, `sw_stable = 0`, debounce counter 0, state IDLE, synchronizer flops 0.
  - The output therefore powers up silent and fades in once the switches are debounced.
  - Reset asserted mid-ramp returns immediately to the reset values.
- **Debounce latency.** An input change reaches `target` 2 + DEBOUNCE_CYCLES + 1 cycles after the pin changes, provided the input stays stable.
- **Step latency.** An `fb` that completes the count in cycle N puts the FSM in STEP in N+1. The new `gain` and the `gain_update` pulse appear in N+2.
- **Ramp duration.** A full ramp of |Δ| codes takes |Δ|·RAMP_FRAMES frame boundaries.
- **IDLE to WAIT.** Entry takes 1 cycle after the target changes. An `fb` in that entry cycle is not counted.
- **Mute.** Mute and unmute ramp like any other target change; there is no hard cut.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RAMP_FRAMES=2, with `fb` pulsed every 16 cycles unless stated.
- Reset release with `sw=4'hA` held: `gain` reads 0 until debounce completes, then steps 0→1→…→A. There are exactly 10 `gain_update` pulses, one per 2 `fb`, and `busy` falls with the final pulse.
- `sw` toggling A↔5 every 3 cycles for 40 cycles: the debouncer never latches, and `gain` stays A with no pulses.
- `mute=1` at gain A: `muted` asserts after 7 cycles, `gain` ramps down to 0 over 20 `fb`. `mute=0` then ramps back up to A.
- Target changed from F to 3 when gain=8 during an up-ramp: the next step gives 7 and the ramp continues down to 3.
- Target changed back to the current gain while in WAIT: the FSM returns to IDLE, no pulse occurs, and `busy` drops.
- `fb` held low (stream stalled) with target ≠ gain: `gain` frozen, `busy=1`. Asserting `reset` mid-WAIT gives `gain=0` and `gain_update=0` in the same cycle, asynchronously.
